// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven fetch front end with a DEPTH-entry prefetch queue; `define FETCH_PERF_EN adds perf counters
module fetch_queue #(
  parameter int AW = 16,
  parameter int IW = 32,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       jmp_en,
  input  logic [AW-1:0]              jmp_loc,
  output logic                       pm_en,
  output logic [AW-1:0]              pm_addr,
  input  logic [IW-1:0]              pm_data,
  output logic [IW-1:0]              ins,
  output logic [AW-1:0]              ins_pc,
  output logic                       ins_valid,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perf_ins,
  output logic [31:0]                perf_flush
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] fpc, infl_pc;
  logic infl, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [IW-1:0] q_ins [DEPTH];
  logic [AW-1:0] q_pc [DEPTH];
  // reads still in flight hold a reserved slot, so a response never overflows
  assign occ = {1'b0, count} + {{CW{1'b0}}, infl};
  assign pm_en = reset & ~jmp_en & (occ < (CW+1)'(DEPTH));
  assign pm_addr = fpc;
  assign push = infl & ~jmp_en;
  assign ins_valid = (count != '0) & ~jmp_en;
  assign pop = ins_valid & ins_ready;
  assign ins = q_ins[rd_ptr];
  assign ins_pc = q_pc[rd_ptr];
  assign q_count = count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fpc <= RESET_PC;
      infl_pc <= RESET_PC;
      infl <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (jmp_en) begin
      fpc <= jmp_loc;
      infl <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      infl <= pm_en;
      if (pm_en) begin
        infl_pc <= fpc;
        fpc <= fpc + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      q_ins[wr_ptr] <= pm_data;
      q_pc[wr_ptr] <= infl_pc;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_ins <= '0;
      perf_flush <= '0;
    end else begin
      if (pop && ~&perf_ins) perf_ins <= perf_ins + 1'b1;
      if (jmp_en && ~&perf_flush) perf_flush <= perf_flush + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table plus queue-based reference model under random stimulus
module tb_fetch_queue;
  localparam int AW = 16, IW = 32, DEPTH = 4, CW = $clog2(DEPTH+1);
  logic clk = 0, reset = 0, jmp_en = 0, ins_ready = 0;
  logic pm_en, ins_valid;
  logic [AW-1:0] jmp_loc = '0, pm_addr, ins_pc;
  logic [IW-1:0] pm_data = '0, ins;
  logic [CW-1:0] q_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_ins, perf_flush;
`endif
  fetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .jmp_en(jmp_en), .jmp_loc(jmp_loc),
    .pm_en(pm_en), .pm_addr(pm_addr), .pm_data(pm_data),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .q_count(q_count)
`ifdef FETCH_PERF_EN
    , .perf_ins(perf_ins), .perf_flush(perf_flush)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction
  always @(posedge clk) if (pm_en) pm_data <= word(pm_addr);
  int total = 0, passed = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  logic [AW-1:0] m_fpc, m_pend_pc;
  bit m_pend;
  logic [AW-1:0] mq[$];
  int unsigned m_pops, m_jumps;
  function automatic bit m_issue();
    return reset && !jmp_en && (mq.size() + int'(m_pend) < DEPTH);
  endfunction
  function automatic bit m_valid();
    return mq.size() != 0 && !jmp_en;
  endfunction
  task automatic m_reset();
    m_fpc = '0;
    m_pend = 0;
    mq.delete();
    m_pops = 0;
    m_jumps = 0;
  endtask
  task automatic m_clock();
    bit iss, pp;
    iss = m_issue();
    pp = m_valid() && ins_ready;
    if (!reset) m_reset();
    else if (jmp_en) begin
      mq.delete();
      m_pend = 0;
      m_fpc = jmp_loc;
      m_jumps++;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (m_pend) mq.push_back(m_pend_pc);
      m_pend = iss;
      if (iss) begin
        m_pend_pc = m_fpc;
        m_fpc = m_fpc + 1'b1;
      end
    end
  endtask
  task automatic model_check();
    chk("pm_en", pm_en, m_issue());
    chk("pm_addr", pm_addr, m_fpc);
    chk("ins_valid", ins_valid, m_valid());
    chk("q_count", q_count, mq.size());
    if (m_valid()) begin
      chk("ins_pc", ins_pc, mq[0]);
      chk("ins", ins, word(mq[0]));
    end
`ifdef FETCH_PERF_EN
    chk("perf_ins", perf_ins, m_pops);
    chk("perf_flush", perf_flush, m_jumps);
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask
  task automatic drive(input bit j, input logic [AW-1:0] loc, input bit r);
    jmp_en = j;
    jmp_loc = loc;
    ins_ready = r;
    #1;
  endtask
  typedef struct {
    bit j; logic [AW-1:0] loc; bit r;
    bit en; logic [AW-1:0] addr; bit v; logic [AW-1:0] pc; int cnt;
  } vec_t;
  vec_t tbl[28];
  initial begin
    tbl[0]  = '{0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0};
    tbl[1]  = '{0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000, 0};
    tbl[2]  = '{0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 1};
    tbl[3]  = '{0, 16'h0000, 0, 1, 16'h0003, 1, 16'h0000, 2};
    tbl[4]  = '{0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 3};
    tbl[5]  = '{0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 4};
    tbl[6]  = '{0, 16'h0000, 1, 0, 16'h0004, 1, 16'h0000, 4};
    tbl[7]  = '{0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0001, 3};
    tbl[8]  = '{0, 16'h0000, 1, 1, 16'h0005, 1, 16'h0002, 2};
    tbl[9]  = '{0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0003, 2};
    tbl[10] = '{0, 16'h0000, 1, 1, 16'h0007, 1, 16'h0004, 2};
    tbl[11] = '{1, 16'h0040, 1, 0, 16'h0008, 0, 16'h0000, 2};
    tbl[12] = '{0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 0};
    tbl[13] = '{0, 16'h0000, 1, 1, 16'h0041, 0, 16'h0000, 0};
    tbl[14] = '{0, 16'h0000, 1, 1, 16'h0042, 1, 16'h0040, 1};
    tbl[15] = '{0, 16'h0000, 1, 1, 16'h0043, 1, 16'h0041, 1};
    tbl[16] = '{1, 16'hFFFE, 1, 0, 16'h0044, 0, 16'h0000, 1};
    tbl[17] = '{0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 0};
    tbl[18] = '{0, 16'h0000, 1, 1, 16'hFFFF, 0, 16'h0000, 0};
    tbl[19] = '{0, 16'h0000, 1, 1, 16'h0000, 1, 16'hFFFE, 1};
    tbl[20] = '{0, 16'h0000, 1, 1, 16'h0001, 1, 16'hFFFF, 1};
    tbl[21] = '{0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 1};
    tbl[22] = '{0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0001, 1};
    tbl[23] = '{1, 16'h0100, 1, 0, 16'h0004, 0, 16'h0000, 1};
    tbl[24] = '{1, 16'h0200, 1, 0, 16'h0100, 0, 16'h0000, 0};
    tbl[25] = '{0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 0};
    tbl[26] = '{0, 16'h0000, 1, 1, 16'h0201, 0, 16'h0000, 0};
    tbl[27] = '{0, 16'h0000, 1, 1, 16'h0202, 1, 16'h0200, 1};
    m_reset();
    repeat (2) @(negedge clk);
    drive(0, '0, 0);
    chk("rst_pm_en", pm_en, 0);
    chk("rst_pm_addr", pm_addr, 16'h0000);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_q_count", q_count, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].j, tbl[i].loc, tbl[i].r);
      chk($sformatf("tbl%0d_pm_en", i), pm_en, tbl[i].en);
      chk($sformatf("tbl%0d_pm_addr", i), pm_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_ins_valid", i), ins_valid, tbl[i].v);
      chk($sformatf("tbl%0d_q_count", i), q_count, tbl[i].cnt);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_ins_pc", i), ins_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_ins", i), ins, word(tbl[i].pc));
      end
      tick();
    end
    repeat (8) begin
      drive(0, '0, 0);
      model_check();
      tick();
    end
    drive(0, '0, 0);
    chk("full_q_count", q_count, DEPTH);
    chk("full_pm_en", pm_en, 0);
    reset = 0;
    #1;
    m_reset();
    chk("midrst_q_count", q_count, 0);
    chk("midrst_pm_addr", pm_addr, 16'h0000);
    chk("midrst_ins_valid", ins_valid, 0);
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1);
      model_check();
      if (i == 0) chk("refetch_addr", pm_addr, 16'h0000);
      if (i == 2) chk("refetch_pc", ins_pc, 16'h0000);
      tick();
    end
    repeat (400) begin
      logic [AW-1:0] loc;
      bit j, r;
      j = $urandom_range(0, 15) == 0;
      loc = $urandom_range(0, 1) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      r = $urandom_range(0, 3) != 0;
      drive(j, loc, r);
      model_check();
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: owns the fetch PC, issues reads to the synchronous program memory, and buffers returned instructions in a DEPTH-entry prefetch queue with a valid/ready handshake toward decode. A jump flushes the queue and any in-flight read, then restarts fetch at the jump target. It replaces the fixed 16/32-bit single-register fetch path; the program memory stays outside the block.

## Interface
Parameters:
- AW, 16, address width (fetch PC and memory address)
- IW, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, fetch PC after reset (AW bits)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- jmp_en  in  1  redirect request this cycle
- jmp_loc  in  AW  redirect target, sampled when jmp_en=1
- pm_en  out  1  memory read strobe
- pm_addr  out  AW  memory read address
- pm_data  in  IW  read data, valid exactly one cycle after pm_en=1
- ins  out  IW  instruction at queue head
- ins_pc  out  AW  address of ins
- ins_valid  out  1  head entry valid
- ins_ready  in  1  decode accepts head (deasserted = stall)
- q_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: fetch PC fpc; in-flight flag infl (read issued last cycle); queue storage of {pc, ins}, write ptr, read ptr, count.
- Issue: pm_en = reset & ~jmp_en & (count + infl < DEPTH). pm_addr = fpc. On issue, fpc <= fpc + 1, wrapping modulo 2^AW (0xFFFF -> 0x0000 at AW=16); address of the issued read is recorded for the response.
- Response: when infl=1 and the read was not flushed, {recorded pc, pm_data} written at wr ptr.
- Pop: ins_valid & ins_ready advances read ptr. ins_valid = (count != 0) & ~jmp_en.
- Credit rule: issue counts in-flight reads, so a response always has a free slot; push and pop in the same cycle keep count unchanged, including when full.
- Jump (jmp_en=1 in cycle t): at the end of t count, pointers clear; fpc <= jmp_loc; a read in flight during t is discarded (infl cleared, data not written); no issue in t. jmp_en has priority over pop, push and issue.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH, never underflows.

## Timing
- Reset (reset=0, asynchronous): fpc=RESET_PC, infl=0, count=0, pointers 0. Outputs: pm_en=0, pm_addr=RESET_PC, ins_valid=0, q_count=0; ins and ins_pc undefined (storage not reset).
- First cycle after reset release: pm_en=1, pm_addr=RESET_PC.
- Issue-to-valid latency: read issued in cycle n -> pm_data in n+1 -> ins_valid in n+2.
- Jump in t -> pm_en=1, pm_addr=jmp_loc in t+1 -> ins_valid with ins_pc=jmp_loc in t+3.
- Steady state with ins_ready=1: one instruction per cycle after initial 2-cycle fill.
- ins_ready=0: queue fills to DEPTH and pm_en drops; ins/ins_pc hold stable while ins_valid=1 and not popped.
- Back-to-back jumps: each jmp_en cycle restarts the sequence; only the last target is fetched.
- Reset asserted mid-operation: all state clears immediately; in-flight data ignored.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_ins [31:0] (count of pop handshakes) and perf_flush [31:0] (count of jmp_en cycles), both cleared by reset, saturating at 0xFFFFFFFF.
- Not defined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset release, ins_ready=1, memory word k = k: ins_valid first high 2 cycles after first pm_en; ins_pc/ins = 0,1,2,3... one per cycle.
- Hold ins_ready=0 for 10 cycles at DEPTH=4: q_count reaches 4, pm_en=0 thereafter, ins_pc stays 0; release -> 0,1,2,3,4 in consecutive cycles, no gap or duplicate.
- jmp_en with jmp_loc=0x0040 while queue holds 3 entries and a read is in flight: ins_valid=0 for t..t+2, at t+3 ins_pc=0x0040, old entries never appear.
- jmp_en and ins_valid&ins_ready in the same cycle: no pop occurs (perf_ins unchanged with FETCH_PERF_EN), flush wins.
- jmp_loc=0xFFFE, AW=16: ins_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset pulsed low for 1 cycle mid-stream with queue full: q_count=0 and pm_addr=RESET_PC immediately; refetch from RESET_PC on release.
